// File: rtl/store_buffer_if.sv
// ============================================================================
// store_buffer_if: pipeline-facing and dmem-facing signals of the store buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     st_valid;
    logic [31:0]              st_addr;
    logic [31:0]              st_data;
    logic                     st_ready;
    logic                     ld_valid;
    logic [31:0]              ld_addr;
    logic                     ld_hit;
    logic [31:0]              ld_data;
    logic                     ld_stall;
    logic                     mem_we;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wd;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wd, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wd, count
    );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer: word-granular store FIFO with load forwarding and forced drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    store_buffer_if.slave   sb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_FULL       = CW'(DEPTH);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;

    logic             w_empty;
    logic             w_full;
    logic             w_force;
    logic             w_accept;
    logic             w_drain;
    logic             w_match;
    logic [31:0]      w_fwd_data;
    logic             w_unused_addr_bits;

    assign w_unused_addr_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_FULL);
    assign w_force  = (r_starve == C_STARVE_MAX);
    assign w_accept = sb.st_valid & ~w_full;
    assign w_drain  = ~w_empty & (~sb.ld_valid | w_force);

    assign sb.st_ready = ~w_full;
    assign sb.mem_we   = w_drain;
    assign sb.mem_addr = w_empty ? 32'h0 : {r_addr[r_head], 2'b00};
    assign sb.mem_wd   = w_empty ? 32'h0 : r_data[r_head];
    assign sb.ld_stall = sb.ld_valid & w_force & ~w_empty;
    assign sb.ld_hit   = sb.ld_valid & w_match;
    assign sb.ld_data  = sb.ld_hit ? w_fwd_data : 32'h0;
    assign sb.count    = r_count;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_match    = 1'b0;
        w_fwd_data = 32'h0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[r_tail - AW'(i + 1)] &&
                (r_addr[r_tail - AW'(i + 1)] == sb.ld_addr[31:2])) begin
                w_match    = 1'b1;
                w_fwd_data = r_data[r_tail - AW'(i + 1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[r_tail] <= sb.st_addr[31:2];
            r_data[r_tail] <= sb.st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_valid  <= '0;
        end else begin
            if (w_accept) begin
                r_tail          <= r_tail + AW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_drain) begin
                r_head          <= r_head + AW'(1);
                r_valid[r_head] <= 1'b0;
            end
            unique case ({w_accept, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_empty || w_drain) begin
                r_starve <= '0;
            end else if (sb.ld_valid && !w_force) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end
endmodule

`default_nettype wire
